// File: rtl/status_event_capture.sv
// Event conditioner feeding the 8-bit status register: sticky edge capture, clear-on-read,
// overflow tracking and a masked registered irq. Define STATUS_EVT_SYNC_EN for a 2-flop input sync.
module status_event_capture #(
  parameter int unsigned WIDTH       = 8,
  parameter logic [7:0]  STICKY_MASK = 8'h00
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] event_in,
  input  logic             rd_strobe,
  input  logic [WIDTH-1:0] int_mask,
  output logic [WIDTH-1:0] status_out,
  output logic [WIDTH-1:0] overflow,
  output logic             irq
);

  localparam logic [WIDTH-1:0] Sticky = STICKY_MASK[WIDTH-1:0];

  typedef enum logic {StIdle, StPending} sticky_st_e;

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] s_d_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] overflow_q, overflow_d;
  logic             irq_q;
  sticky_st_e       st_q [WIDTH];
  sticky_st_e       st_d [WIDTH];

`ifdef STATUS_EVT_SYNC_EN
  logic [WIDTH-1:0] sync1_q, sync2_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= event_in;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = event_in;
`endif

  assign rise = s & ~s_d_q;

  // Per-bit two-state machine; rd_strobe only clears a bit that firmware actually saw as 1.
  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      st_d[i]       = st_q[i];
      overflow_d[i] = overflow_q[i] & ~rd_strobe;
      unique case (st_q[i])
        StIdle: begin
          if (rise[i]) st_d[i] = StPending;
        end
        StPending: begin
          if (rd_strobe && !rise[i]) st_d[i] = StIdle;
          if (rise[i] && !rd_strobe) overflow_d[i] = 1'b1;
        end
        default: st_d[i] = StIdle;
      endcase
      if (!Sticky[i]) begin
        st_d[i]       = StIdle;
        overflow_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pending[i] = (st_q[i] == StPending);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s_d_q      <= '0;
      level_q    <= '0;
      overflow_q <= '0;
      irq_q      <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) st_q[i] <= StIdle;
    end else begin
      s_d_q      <= s;
      level_q    <= s;
      overflow_q <= overflow_d;
      irq_q      <= |(status_out & int_mask);
      for (int unsigned i = 0; i < WIDTH; i++) st_q[i] <= st_d[i];
    end
  end

  assign status_out = (Sticky & pending) | (~Sticky & level_q);
  assign overflow   = overflow_q;
  assign irq        = irq_q;

endmodule
